// File: rtl/or16_arbiter.sv
// or16_arbiter: two-port round-robin arbiter with burst lock sharing one or_16 datapath
// Result is held in a one-deep output register with its own valid/ready handshake.
module or_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    assign y = a | b;
endmodule

module or16_arbiter #(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req0_last,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic        req1_last,
    output logic        req1_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_id,
    input  logic        out_ready
);
    typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;

    state_t      state;
    state_t      next_state;
    logic        prio;
    logic [7:0]  beat_cnt;
    logic        grant;
    logic        grant_valid;
    logic        accept;
    logic        burst_end;
    logic [15:0] or_y;

    or_16 u_or (
        .a(grant ? req1_a : req0_a),
        .b(grant ? req1_b : req0_b),
        .y(or_y)
    );

    always_comb begin
        grant       = 1'b0;
        grant_valid = 1'b0;
        case (state)
            LOCK0: begin
                grant       = 1'b0;
                grant_valid = req0_valid;
            end
            LOCK1: begin
                grant       = 1'b1;
                grant_valid = req1_valid;
            end
            default: begin
                grant       = (req0_valid & req1_valid) ? prio : req1_valid;
                grant_valid = req0_valid | req1_valid;
            end
        endcase
    end

    // A beat may be taken in the same cycle the held result drains.
    assign accept    = (!out_valid | out_ready) & grant_valid & !reset;
    assign burst_end = (grant ? req1_last : req0_last) | ({1'b0, beat_cnt} + 9'd1 == 9'(MAX_BURST));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            prio     <= 1'b0;
            beat_cnt <= 8'd0;
        end else begin
            state    <= next_state;
            prio     <= (accept & burst_end) ? ~grant : prio;
            beat_cnt <= accept ? (burst_end ? 8'd0 : beat_cnt + 8'd1) : beat_cnt;
        end
    end

    always_comb begin
        next_state = state;
        if (accept) next_state = burst_end ? IDLE : (grant ? LOCK1 : LOCK0);
    end

    always_comb begin
        req0_ready = accept & !grant;
        req1_ready = accept & grant;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
            out_id    <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= or_y;
            out_id    <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_or16_arbiter.sv
// tb_or16_arbiter: directed vectors for or16_arbiter; dut uses MAX_BURST=8, dut2 MAX_BURST=2
module tb_or16_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        out_ready = 1'b1;
    logic        r0_rdy, r1_rdy, o_valid, o_id;
    logic [15:0] o_data;
    logic        r0_rdy2, r1_rdy2, o_valid2, o_id2;
    logic [15:0] o_data2;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    or16_arbiter #(.MAX_BURST(8)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_last(req0_last), .req0_ready(r0_rdy),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_last(req1_last), .req1_ready(r1_rdy),
        .out_valid(o_valid), .out_data(o_data), .out_id(o_id), .out_ready(out_ready)
    );

    or16_arbiter #(.MAX_BURST(2)) dut2 (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_last(req0_last), .req0_ready(r0_rdy2),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_last(req1_last), .req1_ready(r1_rdy2),
        .out_valid(o_valid2), .out_data(o_data2), .out_id(o_id2), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_last = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_last = 1'b0; req1_a = '0; req1_b = '0;
        out_ready  = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #1;
        // reset state, with a request pending to prove ready is masked
        req0_valid = 1'b1; req0_last = 1'b1;
        #1;
        chk("rst_ready0", r0_rdy, 0);
        tick();
        chk("rst_out_valid", o_valid, 0);
        chk("rst_out_data", o_data, 16'h0000);
        chk("rst_out_id", o_id, 0);
        chk("rst_prio", dut.prio, 0);
        do_reset();

        // single beat
        req0_valid = 1'b1; req0_a = 16'h00F0; req0_b = 16'h0F01; req0_last = 1'b1;
        #1;
        chk("single_ready0", r0_rdy, 1);
        chk("single_ready1", r1_rdy, 0);
        tick();
        req0_valid = 1'b0;
        chk("single_valid", o_valid, 1);
        chk("single_data", o_data, 16'h0FF1);
        chk("single_id", o_id, 0);
        chk("single_state", dut.state, 0);
        chk("single_prio", dut.prio, 1);
        tick();
        chk("single_drain", o_valid, 0);

        // contention round-robin
        do_reset();
        req0_valid = 1'b1; req0_a = 16'h1100; req0_b = 16'h0011; req0_last = 1'b1;
        req1_valid = 1'b1; req1_a = 16'h2200; req1_b = 16'h0022; req1_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready0", r0_rdy, (i % 2) == 0);
            chk("rr_ready1", r1_rdy, (i % 2) == 1);
            tick();
            chk("rr_id", o_id, i % 2);
            chk("rr_data", o_data, (i % 2) ? 16'h2222 : 16'h1111);
        end

        // burst lock: port 0 three beats, port 1 waits
        do_reset();
        req1_valid = 1'b1; req1_a = 16'h0300; req1_b = 16'h0030; req1_last = 1'b1;
        req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            req0_a = 16'(i + 1);
            req0_last = (i == 2);
            #1;
            chk("lock_ready0", r0_rdy, 1);
            chk("lock_ready1", r1_rdy, 0);
            tick();
            chk("lock_id", o_id, 0);
            chk("lock_data", o_data, 32'(i + 1));
        end
        req0_valid = 1'b0;
        #1;
        chk("lock_ready1_after", r1_rdy, 1);
        tick();
        chk("lock_id_after", o_id, 1);
        chk("lock_data_after", o_data, 16'h0330);

        // forced release on the MAX_BURST=2 instance
        do_reset();
        req0_valid = 1'b1; req0_a = 16'h000A; req0_b = 16'h00A0; req0_last = 1'b0;
        req1_valid = 1'b1; req1_a = 16'h0B00; req1_b = 16'hB000; req1_last = 1'b1;
        begin
            logic [4:0] ids;
            logic [4:0] cnts;
            ids  = 5'b00100;
            cnts = 5'b01001;
            for (int i = 0; i < 5; i++) begin
                #1;
                chk("force_ready0", r0_rdy2, !ids[i]);
                chk("force_ready1", r1_rdy2, ids[i]);
                tick();
                chk("force_id", o_id2, ids[i]);
                chk("force_data", o_data2, ids[i] ? 16'hBB00 : 16'h00AA);
                chk("force_cnt", dut2.beat_cnt, cnts[i]);
            end
        end

        // backpressure
        do_reset();
        req0_valid = 1'b1; req0_a = 16'hAB00; req0_b = 16'h00CD; req0_last = 1'b1;
        tick();
        chk("bp_first", o_data, 16'hABCD);
        out_ready = 1'b0;
        req0_a = 16'h1234; req0_b = 16'h0000;
        req1_valid = 1'b1; req1_a = 16'h5678; req1_b = 16'h0000; req1_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready0", r0_rdy, 0);
            chk("bp_ready1", r1_rdy, 0);
            tick();
            chk("bp_hold_data", o_data, 16'hABCD);
            chk("bp_hold_valid", o_valid, 1);
            chk("bp_hold_id", o_id, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready1", r1_rdy, 1);
        chk("bp_release_ready0", r0_rdy, 0);
        tick();
        chk("bp_next_data", o_data, 16'h5678);
        chk("bp_next_id", o_id, 1);

        // mid-burst reset
        do_reset();
        req1_valid = 1'b1; req1_a = 16'h0001; req1_b = 16'h0000; req1_last = 1'b0;
        tick();
        tick();
        chk("mid_state_lock1", dut.state, 2);
        chk("mid_cnt", dut.beat_cnt, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_out_valid", o_valid, 0);
        chk("mid_prio", dut.prio, 0);
        chk("mid_state", dut.state, 0);
        chk("mid_cnt_clr", dut.beat_cnt, 0);
        req0_valid = 1'b1; req0_a = 16'h0040; req0_b = 16'h0004; req0_last = 1'b1;
        req1_last = 1'b1;
        #1;
        chk("mid_grant0", r0_rdy, 1);
        chk("mid_grant1", r1_rdy, 0);
        tick();
        chk("mid_id", o_id, 0);
        chk("mid_data", o_data, 16'h0044);

        idle_inputs();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/or16_arbiter.md
Name: or16_arbiter

Overview:
- Two-requester round-robin arbiter that time-shares a single or_16 datapath instance.
- Each requester presents operand pairs (a, b) over a valid/ready handshake, optionally as multi-beat bursts.
- The arbiter grants one port per cycle and registers a|b with the source port id into a one-deep output stage with its own valid/ready handshake.
- It sits between ALU-side clients and the shared bitwise-OR resource.

Parameters:
- MAX_BURST, 8, maximum beats a port may hold the grant before lock is force-released; legal range 1..255.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 has an operand pair
- req0_a  in  16  port 0 operand a
- req0_b  in  16  port 0 operand b
- req0_last  in  1  port 0 beat is final beat of its burst
- req0_ready  out  1  port 0 beat accepted this cycle (valid & ready)
- req1_valid, req1_a, req1_b, req1_last, req1_ready: same as port 0, for port 1
- out_valid  out  1  result register holds a result
- out_data  out  16  registered a|b of granted beat
- out_id  out  1  port that produced out_data
- out_ready  in  1  consumer takes result when out_valid & out_ready

Behaviour:
- Single clock domain; reset is synchronous, active-high.
- Reset values:
  - out_valid=0, out_data=16'h0000, out_id=0.
  - state=IDLE, prio=0 (port 0 favoured first), beat_cnt=0.
  - req*_ready=0 while reset is high.
- slot_free = !out_valid | out_ready. A beat can be accepted in the same cycle the current result drains; this gives full throughput of 1 beat/cycle.
- Grant (combinational, from state and valids):
  - IDLE, one port valid: that port.
  - IDLE, both valid: port == prio.
  - LOCK0: port 0 only; port 1 is ignored even if valid.
  - LOCK1: port 1 only.
- reqN_ready = slot_free & (grant==N) & reqN_valid & !reset. Never both high in one cycle.
- Accepted beat:
  - out_data <= reqN_a | reqN_b, computed through one or_16 instance; operands are muxed by grant.
  - out_id <= N; out_valid <= 1. Latency is 1 cycle from acceptance to out_valid.
- No accept & out_ready: out_valid <= 0.
- No accept & !out_ready: out_data, out_id and out_valid all hold. The registered result is never overwritten while stalled.
- Effective end of burst: accepted beat with last=1, or beat_cnt+1 == MAX_BURST.
- FSM transitions:
  - IDLE -> LOCKN on an accepted non-final beat from port N; beat_cnt <= 1.
  - LOCKN -> LOCKN on an accepted non-final beat; beat_cnt++.
  - LOCKN -> IDLE on an accepted final beat (including forced release); beat_cnt <= 0.
  - IDLE with accepted final beat (single-beat burst): stay IDLE.
- prio update: at every effective end of burst from port N, prio <= ~N. Otherwise prio holds.
- Requesters must hold valid, a, b and last stable until ready. The arbiter does not check this.
- MAX_BURST=1: every beat is final; ports alternate per beat when both are valid.
- Reset asserted mid-burst: lock, counter and output are dropped to reset values the next edge. The in-flight result is discarded.
- out_ready high while out_valid=0: harmless, no effect.

Test Plan:
- Single beat: reset, then req0_valid=1, a=16'h00F0, b=16'h0F01, last=1, out_ready=1 -> req0_ready=1 that cycle. Next cycle: out_valid=1, out_data=16'h0FF1, out_id=0; state IDLE; prio=1.
- Contention round-robin: both ports valid with last=1, out_ready=1 for 4 cycles; port0 a|b=16'h1111, port1 a|b=16'h2222 -> outputs alternate id 0,1,0,1 with 16'h1111/16'h2222.
- Burst lock: port0 sends 3 beats (last on beat 3) while port1 is valid throughout -> req1_ready=0 for all 3 beats. Port 1 is granted on cycle 4; out_id sequence 0,0,0,1.
- Forced release, MAX_BURST=2: port0 holds last=0 for 4 beats, port1 valid -> out_id sequence 0,0,1,0,0. beat_cnt returns to 0 after each pair.
- Backpressure: out_ready=0 after first result 16'hABCD -> out_data stays 16'hABCD and both readies stay 0 for 5 cycles. Raise out_ready -> the next beat is accepted in the same cycle.
- Mid-burst reset: port1 in LOCK1 after 2 beats, assert reset 1 cycle -> out_valid=0, prio=0. With both ports valid after reset, port 0 is granted first.
